// File: rtl/ntt_common_pkg.sv
// Parameters shared by every block of the NTT core.
package ntt_common_pkg;

    localparam int PSI = 128;

endpackage

// File: rtl/ntt_core_stage_seq_pkg.sv
// Geometry and state encoding of the NTT stage sequencer.
package ntt_core_stage_seq_pkg;

    localparam int PSI   = ntt_common_pkg::PSI;
    localparam int N     = 2048;
    localparam int NB    = N / (2 * PSI);
    localparam int S     = $clog2(N);
    localparam int STG_W = $clog2(S);
    localparam int BLK_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW_W  = $clog2(S * NB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ntt_core_seq_wrap_cnt.sv
// Loadable up/down counter that wraps between 0 and a programmable bound.
module ntt_core_seq_wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         s_rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic [W-1:0] bound_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = (inc_i && (cnt_q == bound_i)) || (dec_i && (cnt_q == '0));
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = (cnt_q == bound_i) ? '0 : cnt_q + 1'b1;
        end else if (dec_i) begin
            cnt_d = (cnt_q == '0) ? bound_i : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ntt_core_stage_seq.sv
// Walks stage x polynomial x block for one NTT command, one control beat per cycle,
// with a fixed drain bubble between stages.
//
// state | meaning
// IDLE  | waiting for a command, cmd_rdy high
// RUN   | issuing control beats
// GAP   | inter-stage bubble, ctrl_avail low for STG_GAP cycles
// FIN   | one-cycle done pulse
module ntt_core_stage_seq
    import ntt_core_stage_seq_pkg::*;
#(
    parameter int PSI     = ntt_core_stage_seq_pkg::PSI,
    parameter int N       = ntt_core_stage_seq_pkg::N,
    parameter int STG_GAP = 4,
    parameter int POLY_W  = 8
) (
    input  logic              clk,
    input  logic              s_rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_intt,
    input  logic [POLY_W-1:0] cmd_poly_nb,
    output logic              ctrl_avail,
    input  logic              ctrl_rdy,
    output logic [STG_W-1:0]  ctrl_stg,
    output logic [POLY_W-1:0] ctrl_poly,
    output logic [BLK_W-1:0]  ctrl_blk,
    output logic [TW_W-1:0]   ctrl_tw_addr,
    output logic              ctrl_intt,
    output logic              ctrl_sos,
    output logic              ctrl_eos,
    output logic              ctrl_eot,
    output logic              done,
    output logic              busy
);

    if (PSI != ntt_core_stage_seq_pkg::PSI || N != ntt_core_stage_seq_pkg::N) begin : g_cfg_check
        $error("ntt_core_stage_seq: PSI/N must match ntt_core_stage_seq_pkg");
    end

    localparam int GAP_W = (STG_GAP > 1) ? $clog2(STG_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((STG_GAP > 0) ? STG_GAP - 1 : 0);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(S - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NB - 1);

    seq_state_e        state_q, state_d;
    logic              intt_q;
    logic [POLY_W-1:0] poly_nb_q;

    logic              cmd_hs, beat, stage_end;
    logic [STG_W-1:0]  stg_cnt;
    logic [POLY_W-1:0] poly_cnt;
    logic [BLK_W-1:0]  blk_cnt;
    logic [GAP_W-1:0]  gap_cnt_unused;
    logic              stg_wrap, poly_wrap, blk_wrap, gap_wrap;

    assign cmd_rdy   = (state_q == ST_IDLE) && !s_rst;
    assign cmd_hs    = cmd_vld && cmd_rdy;
    assign beat      = ctrl_avail && ctrl_rdy;
    assign stage_end = beat && blk_wrap && poly_wrap;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q   <= ST_IDLE;
            intt_q    <= 1'b0;
            poly_nb_q <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_hs) begin
                intt_q    <= cmd_intt;
                poly_nb_q <= cmd_poly_nb;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_hs) state_d = (cmd_poly_nb != '0) ? ST_RUN : ST_FIN;
            ST_RUN: begin
                if (stage_end) begin
                    if (stg_wrap)         state_d = ST_FIN;
                    else if (STG_GAP > 0) state_d = ST_GAP;
                end
            end
            ST_GAP:  if (gap_wrap) state_d = ST_RUN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    ntt_core_seq_wrap_cnt #(.W(BLK_W)) u_blk_cnt (
        .clk(clk), .s_rst(s_rst),
        .load_i(cmd_hs), .load_val_i('0),
        .inc_i(beat), .dec_i(1'b0), .bound_i(BLK_LAST),
        .cnt_o(blk_cnt), .wrap_o(blk_wrap)
    );

    ntt_core_seq_wrap_cnt #(.W(POLY_W)) u_poly_cnt (
        .clk(clk), .s_rst(s_rst),
        .load_i(cmd_hs), .load_val_i('0),
        .inc_i(beat && blk_wrap), .dec_i(1'b0), .bound_i(poly_nb_q - 1'b1),
        .cnt_o(poly_cnt), .wrap_o(poly_wrap)
    );

    // Inverse transforms walk the stages downward; the wrap marks the final stage either way.
    ntt_core_seq_wrap_cnt #(.W(STG_W)) u_stg_cnt (
        .clk(clk), .s_rst(s_rst),
        .load_i(cmd_hs), .load_val_i(cmd_intt ? STG_LAST : '0),
        .inc_i(stage_end && !intt_q), .dec_i(stage_end && intt_q), .bound_i(STG_LAST),
        .cnt_o(stg_cnt), .wrap_o(stg_wrap)
    );

    ntt_core_seq_wrap_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk(clk), .s_rst(s_rst),
        .load_i(stage_end && !stg_wrap), .load_val_i(GAP_LOAD),
        .inc_i(1'b0), .dec_i(state_q == ST_GAP), .bound_i(GAP_LOAD),
        .cnt_o(gap_cnt_unused), .wrap_o(gap_wrap)
    );

    assign ctrl_avail   = (state_q == ST_RUN);
    assign ctrl_stg     = stg_cnt;
    assign ctrl_poly    = poly_cnt;
    assign ctrl_blk     = blk_cnt;
    assign ctrl_tw_addr = TW_W'(stg_cnt) * TW_W'(NB) + TW_W'(blk_cnt);
    assign ctrl_intt    = intt_q;
    assign ctrl_sos     = ctrl_avail && (poly_cnt == '0) && (blk_cnt == '0);
    assign ctrl_eos     = ctrl_avail && (poly_cnt == poly_nb_q - 1'b1) && (blk_cnt == BLK_LAST);
    assign ctrl_eot     = ctrl_eos && (stg_cnt == (intt_q ? '0 : STG_LAST));
    assign done         = (state_q == ST_FIN);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/ntt_core_stage_seq.md
# ntt_core_stage_seq

Control sequencer for the PSI-butterfly NTT core (PSI = 128 butterflies per cycle). It accepts one transform command for a batch of polynomials and walks stage × polynomial × block. Each cycle it issues one control beat: stage index, block index, polynomial index, twiddle address and framing flags. Between stages it inserts a programmable bubble so the butterfly pipeline can drain before the next stage reads back its results.

## Interface
Parameters:
- PSI, 128, butterflies per cycle; each beat covers 2·PSI coefficients.
- N, 2048, polynomial size (power of 2, ≥ 2·PSI).
- STG_GAP, 4, minimum idle cycles between the last beat of a stage and the first beat of the next (0 allowed).
- POLY_W, 8, width of polynomial count.

Derived: NB = N/(2·PSI) blocks per stage; S = log2(N) stages; STG_W = clog2(S); BLK_W = clog2(NB) (min 1); TW_W = clog2(S·NB).

Ports:
- clk  in  1  clock
- s_rst  in  1  reset; synchronous, active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; high only in IDLE
- cmd_intt  in  1  1 = inverse transform
- cmd_poly_nb  in  POLY_W  number of polynomials in batch
- ctrl_avail  out  1  control beat valid
- ctrl_rdy  in  1  core accepts beat
- ctrl_stg  out  STG_W  stage index
- ctrl_poly  out  POLY_W  polynomial index
- ctrl_blk  out  BLK_W  block index within polynomial
- ctrl_tw_addr  out  TW_W  twiddle ROM address = stg·NB + blk
- ctrl_intt  out  1  latched cmd_intt
- ctrl_sos / ctrl_eos  out  1  first / last beat of a stage
- ctrl_eot  out  1  last beat of the transform
- done  out  1  one-cycle pulse, transform complete
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: cmd_rdy = 1. On handshake, latch intt and poly_nb. Go to RUN if poly_nb ≠ 0, else to FIN.
  - RUN: issue beats. A beat completes on ctrl_avail & ctrl_rdy.
  - GAP: count STG_GAP cycles, ctrl_avail = 0, then go to RUN.
  - FIN: pulse done for one cycle, then go to IDLE.
- Loop order per beat: blk increments fastest (0..NB-1), then poly (0..poly_nb-1), then stage.
- Stage order: forward runs 0→S-1; inverse runs S-1→0.
- ctrl_sos = (poly==0 & blk==0). ctrl_eos = (poly==poly_nb-1 & blk==NB-1). ctrl_eot = ctrl_eos & final stage.
- Completing an eos beat:
  - eot beat → FIN.
  - otherwise, STG_GAP > 0 → GAP; STG_GAP = 0 → stay in RUN, next stage issued back-to-back.
- Arithmetic: counters wrap at their bounds with no overflow. ctrl_tw_addr is computed from the stage and block values of the same beat.
- Commands are ignored outside IDLE because cmd_rdy = 0.

## Timing
- Reset values: ctrl_avail, done, busy, all ctrl_* = 0; state = IDLE. cmd_rdy = 0 while s_rst = 1 and 1 on the first cycle after reset release.
- All ctrl_* outputs are registered. A command handshake at cycle t gives the first ctrl_avail at t+1.
- Payload and flags hold stable while ctrl_avail & !ctrl_rdy. A beat is never dropped or repeated.
- With ctrl_rdy held at 1, beats within a stage are back-to-back. After eos, ctrl_avail is low for exactly STG_GAP cycles.
- done asserts the cycle after the eot handshake. With poly_nb = 0, done asserts at t+1 and no beats are issued.
- Total cycles, from first beat to eot, with ctrl_rdy = 1: S·poly_nb·NB + (S-1)·STG_GAP.
- s_rst asserted mid-transform aborts the transform: next cycle all outputs are at reset values, no done pulse, state IDLE.

## Structure
- Shared package ntt_core_stage_seq_pkg holds:
  - the state enum (IDLE, RUN, GAP, FIN);
  - the derived localparams NB, S, STG_W, BLK_W, TW_W, computed from PSI/N, with PSI taken from the common NTT parameter package.
- One sub-module is natural: ntt_core_seq_wrap_cnt, a load/increment/decrement counter with a programmable bound and a wrap flag. It is instantiated for blk, poly, stage and the gap count.

## Test plan
- Forward, N=2048, PSI=128, poly_nb=1, STG_GAP=4, ctrl_rdy=1 → 88 beats; tw_addr runs 0..87 in order; sos/eos every 8 beats; 128 cycles from first beat to eot; done at eot+1.
- Inverse, poly_nb=2 → first beat stg=10, blk=0, poly=0, tw_addr=80; blk wraps 7→0 with poly 0→1; last beat stg=0, poly=1, blk=7, tw_addr=7, eot=1.
- Random ctrl_rdy at 50 % → payload stable while stalled; beat sequence identical to the no-stall run; cmd_vld pulses during busy are ignored.
- poly_nb=0 → no ctrl_avail; done at t+1; cmd_rdy high again at t+2.
- STG_GAP=0, poly_nb=1 → 88 consecutive beats with no bubble.
- s_rst asserted on beat 40 → all outputs 0 the next cycle, no done. A new forward command after reset restarts at tw_addr 0.
